serv_mem_arbiter: RTL and testbench

- Shares one downstream split-channel memory port between the SERV core's instruction and data ports.
- Channels: ca = command/address, dm = write data/mask, rd = read data.
- Arbitrates the ca channel round-robin, holds the winner stable under backpressure, gates dm to accepted writes, and returns read data in order to the requester that issued each read.
- Sits between serv_top and the memory model or system bus.

---
 rtl/serv_mem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_serv_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_mem_arbiter.sv
// serv_mem_arbiter
//   Shares one downstream split-channel memory port between the SERV
//   instruction and data ports.
//   - ca (command/address): round-robin arbitration. The winner is held
//     stable while the downstream port applies backpressure.
//   - dm (write data/mask): forwarded only for write commands that were
//     already accepted but have not yet sent their data beat.
//   - rd (read data): returned in issue order to the source that issued
//     each read, using a small order FIFO.
// Ports
//   clock, resetn            : clock and asynchronous active-low reset
//   i_i_ca_* / o_i_ca_rdy    : instruction fetch request
//   o_i_rd_* / i_i_rd_rdy    : instruction fetch response
//   i_d_ca_* / o_d_ca_rdy    : data request (cmd 1=write, 0=read)
//   i_d_dm_* / o_d_dm_rdy    : data write beat
//   o_d_rd_* / i_d_rd_rdy    : data load response
//   o_m_ca_*, o_m_dm_*, i_m_rd_* : downstream memory port
//   o_err                    : sticky flag, set when read data arrives with
//                              no read outstanding
module serv_mem_arbiter #(
   parameter int RD_DEPTH = 4,
   parameter int WR_DEPTH = 2
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] i_i_ca_adr,
   input  logic        i_i_ca_vld,
   output logic        o_i_ca_rdy,
   output logic [31:0] o_i_rd_dat,
   output logic        o_i_rd_vld,
   input  logic        i_i_rd_rdy,
   input  logic        i_d_ca_cmd,
   input  logic [31:0] i_d_ca_adr,
   input  logic        i_d_ca_vld,
   output logic        o_d_ca_rdy,
   input  logic [31:0] i_d_dm_dat,
   input  logic [3:0]  i_d_dm_msk,
   input  logic        i_d_dm_vld,
   output logic        o_d_dm_rdy,
   output logic [31:0] o_d_rd_dat,
   output logic        o_d_rd_vld,
   input  logic        i_d_rd_rdy,
   output logic        o_m_ca_cmd,
   output logic [31:0] o_m_ca_adr,
   output logic        o_m_ca_vld,
   input  logic        i_m_ca_rdy,
   output logic [31:0] o_m_dm_dat,
   output logic [3:0]  o_m_dm_msk,
   output logic        o_m_dm_vld,
   input  logic        i_m_dm_rdy,
   input  logic [31:0] i_m_rd_dat,
   input  logic        i_m_rd_vld,
   output logic        o_m_rd_rdy,
   output logic        o_err
);

   localparam int PTR_W  = $clog2(RD_DEPTH);
   localparam int WCNT_W = $clog2(WR_DEPTH + 1);
   localparam logic [WCNT_W-1:0] WR_MAX = WCNT_W'(WR_DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_I = 2'd1,
      LOCK_D = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              last_d_q, last_d_d;     // 1: last ca grant went to D
   logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              err_q, err_d;

   // Order FIFO: one entry per outstanding read, 0=I, 1=D.
   logic              fifo_mem [RD_DEPTH];

   logic fifo_empty, fifo_full, fifo_head;
   logic i_elig, d_elig;
   logic sel_d, m_ca_vld, ca_hs, push, pop, wr_hs, dm_hs, wcnt_nz;

   // The pointers carry one extra wrap bit so that a full FIFO can be told
   // apart from an empty one.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign fifo_head  = fifo_mem[rd_ptr_q[PTR_W-1:0]];

   assign i_elig = i_i_ca_vld && !fifo_full;
   assign d_elig = i_d_ca_vld && (i_d_ca_cmd ? (wcnt_q < WR_MAX) : !fifo_full);

   // ---------------- ca FSM: state register ----------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         last_d_q <= 1'b1;   // treat D as last granted, so I wins the first tie
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
      end
   end

   // ---------------- ca FSM: output / mux logic ----------------
   // Winner selection looks only at state and eligibility, never at
   // i_m_ca_rdy. That keeps o_m_ca_* free of any combinational path from
   // the downstream ready.
   always_comb begin
      sel_d = 1'b0;
      case (state_q)
         LOCK_I:  sel_d = 1'b0;
         LOCK_D:  sel_d = 1'b1;
         default: sel_d = (i_elig && d_elig) ? !last_d_q : d_elig;
      endcase
      m_ca_vld   = sel_d ? d_elig : i_elig;
      o_m_ca_vld = resetn && m_ca_vld;
      o_m_ca_cmd = sel_d && i_d_ca_cmd;
      o_m_ca_adr = sel_d ? i_d_ca_adr : i_i_ca_adr;
      // The ready is qualified with the winner's eligibility. Otherwise a
      // source blocked by a full FIFO or write limit could see a stray
      // handshake.
      o_i_ca_rdy = resetn && m_ca_vld && !sel_d && i_m_ca_rdy;
      o_d_ca_rdy = resetn && m_ca_vld &&  sel_d && i_m_ca_rdy;
   end

   assign ca_hs = o_m_ca_vld && i_m_ca_rdy;
   assign push  = ca_hs && !o_m_ca_cmd;
   assign wr_hs = ca_hs &&  o_m_ca_cmd;

   // ---------------- ca FSM: next-state logic ----------------
   always_comb begin
      state_d  = state_q;
      last_d_d = ca_hs ? sel_d : last_d_q;
      case (state_q)
         IDLE: begin
            if (m_ca_vld && !i_m_ca_rdy)
               state_d = sel_d ? LOCK_D : LOCK_I;
         end
         default: begin
            // The lock is released on completion. It is also released if
            // the locked source withdraws its request, so the arbiter can
            // never stall.
            if (ca_hs || !m_ca_vld)
               state_d = IDLE;
         end
      endcase
   end

   // ---------------- read return ----------------
   always_comb begin
      o_i_rd_dat = i_m_rd_dat;
      o_d_rd_dat = i_m_rd_dat;
      o_i_rd_vld = 1'b0;
      o_d_rd_vld = 1'b0;
      o_m_rd_rdy = resetn;   // with nothing outstanding, unexpected data is drained
      if (!fifo_empty) begin
         o_i_rd_vld = resetn && i_m_rd_vld && !fifo_head;
         o_d_rd_vld = resetn && i_m_rd_vld &&  fifo_head;
         o_m_rd_rdy = resetn && (fifo_head ? i_d_rd_rdy : i_i_rd_rdy);
      end
   end

   assign pop   = !fifo_empty && i_m_rd_vld && o_m_rd_rdy;
   assign err_d = err_q || (fifo_empty && i_m_rd_vld);
   assign o_err = err_q;

   // ---------------- dm channel ----------------
   assign wcnt_nz    = (wcnt_q != '0);
   assign o_m_dm_vld = resetn && i_d_dm_vld && wcnt_nz;
   assign o_d_dm_rdy = resetn && i_m_dm_rdy && wcnt_nz;
   assign o_m_dm_dat = i_d_dm_dat;
   assign o_m_dm_msk = i_d_dm_msk;
   assign dm_hs      = o_m_dm_vld && i_m_dm_rdy;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;
      case ({wr_hs, dm_hs})
         2'b10:   wcnt_d = wcnt_q + WCNT_W'(1);
         2'b01:   wcnt_d = wcnt_q - WCNT_W'(1);
         default: wcnt_d = wcnt_q;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         wcnt_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         wcnt_q   <= wcnt_d;
         err_q    <= err_d;
      end
   end

   // FIFO storage needs no reset. The pointers alone define which entries
   // are valid.
   always_ff @(posedge clock) begin
      if (push)
         fifo_mem[wr_ptr_q[PTR_W-1:0]] <= sel_d;
   end

endmodule

// File: tb/tb_serv_mem_arbiter.sv
module tb_serv_mem_arbiter;

   logic        clock = 1'b0;
   logic        resetn;
   logic [31:0] i_i_ca_adr;
   logic        i_i_ca_vld;
   logic        o_i_ca_rdy;
   logic [31:0] o_i_rd_dat;
   logic        o_i_rd_vld;
   logic        i_i_rd_rdy;
   logic        i_d_ca_cmd;
   logic [31:0] i_d_ca_adr;
   logic        i_d_ca_vld;
   logic        o_d_ca_rdy;
   logic [31:0] i_d_dm_dat;
   logic [3:0]  i_d_dm_msk;
   logic        i_d_dm_vld;
   logic        o_d_dm_rdy;
   logic [31:0] o_d_rd_dat;
   logic        o_d_rd_vld;
   logic        i_d_rd_rdy;
   logic        o_m_ca_cmd;
   logic [31:0] o_m_ca_adr;
   logic        o_m_ca_vld;
   logic        i_m_ca_rdy;
   logic [31:0] o_m_dm_dat;
   logic [3:0]  o_m_dm_msk;
   logic        o_m_dm_vld;
   logic        i_m_dm_rdy;
   logic [31:0] i_m_rd_dat;
   logic        i_m_rd_vld;
   logic        o_m_rd_rdy;
   logic        o_err;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   serv_mem_arbiter #(.RD_DEPTH(4), .WR_DEPTH(2)) dut (
      .clock(clock), .resetn(resetn),
      .i_i_ca_adr(i_i_ca_adr), .i_i_ca_vld(i_i_ca_vld), .o_i_ca_rdy(o_i_ca_rdy),
      .o_i_rd_dat(o_i_rd_dat), .o_i_rd_vld(o_i_rd_vld), .i_i_rd_rdy(i_i_rd_rdy),
      .i_d_ca_cmd(i_d_ca_cmd), .i_d_ca_adr(i_d_ca_adr), .i_d_ca_vld(i_d_ca_vld),
      .o_d_ca_rdy(o_d_ca_rdy),
      .i_d_dm_dat(i_d_dm_dat), .i_d_dm_msk(i_d_dm_msk), .i_d_dm_vld(i_d_dm_vld),
      .o_d_dm_rdy(o_d_dm_rdy),
      .o_d_rd_dat(o_d_rd_dat), .o_d_rd_vld(o_d_rd_vld), .i_d_rd_rdy(i_d_rd_rdy),
      .o_m_ca_cmd(o_m_ca_cmd), .o_m_ca_adr(o_m_ca_adr), .o_m_ca_vld(o_m_ca_vld),
      .i_m_ca_rdy(i_m_ca_rdy),
      .o_m_dm_dat(o_m_dm_dat), .o_m_dm_msk(o_m_dm_msk), .o_m_dm_vld(o_m_dm_vld),
      .i_m_dm_rdy(i_m_dm_rdy),
      .i_m_rd_dat(i_m_rd_dat), .i_m_rd_vld(i_m_rd_vld), .o_m_rd_rdy(o_m_rd_rdy),
      .o_err(o_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // ---- reset: every vld/rdy output and o_err must read 0 ----
      resetn     = 1'b0;
      i_i_ca_adr = 32'h0;  i_i_ca_vld = 1'b1;
      i_d_ca_cmd = 1'b0;   i_d_ca_adr = 32'h0;  i_d_ca_vld = 1'b1;
      i_d_dm_dat = 32'h0;  i_d_dm_msk = 4'h0;   i_d_dm_vld = 1'b1;
      i_m_rd_dat = 32'h0;  i_m_rd_vld = 1'b1;
      i_m_ca_rdy = 1'b1;   i_m_dm_rdy = 1'b1;
      i_i_rd_rdy = 1'b1;   i_d_rd_rdy = 1'b1;
      tick(); tick();
      check("rst_m_ca_vld", 32'(o_m_ca_vld), 0);
      check("rst_i_ca_rdy", 32'(o_i_ca_rdy), 0);
      check("rst_d_ca_rdy", 32'(o_d_ca_rdy), 0);
      check("rst_m_rd_rdy", 32'(o_m_rd_rdy), 0);
      check("rst_i_rd_vld", 32'(o_i_rd_vld), 0);
      check("rst_m_dm_vld", 32'(o_m_dm_vld), 0);
      check("rst_err",      32'(o_err), 0);
      i_i_ca_vld = 1'b0; i_d_ca_vld = 1'b0; i_d_dm_vld = 1'b0; i_m_rd_vld = 1'b0;
      resetn = 1'b1;
      tick();

      // ---- round robin: I, D, I, D reads, FIFO fills ----
      i_i_ca_adr = 32'h100; i_d_ca_adr = 32'h200; i_d_ca_cmd = 1'b0;
      i_i_ca_vld = 1'b1;    i_d_ca_vld = 1'b1;
      for (int k = 0; k < 4; k++) begin
         logic exp_d;
         exp_d = k[0];
         settle();
         check("rr_adr",   o_m_ca_adr, exp_d ? 32'h200 : 32'h100);
         check("rr_i_rdy", 32'(o_i_ca_rdy), 32'(!exp_d));
         check("rr_d_rdy", 32'(o_d_ca_rdy), 32'(exp_d));
         tick();
      end
      settle();
      check("full_m_vld", 32'(o_m_ca_vld), 0);
      check("full_i_rdy", 32'(o_i_ca_rdy), 0);
      check("full_d_rdy", 32'(o_d_ca_rdy), 0);
      // writes still go through while the read FIFO is full
      i_d_ca_cmd = 1'b1;
      settle();
      check("full_wr_d_rdy", 32'(o_d_ca_rdy), 1);
      check("full_wr_cmd",   32'(o_m_ca_cmd), 1);
      tick();
      settle();
      check("wr2_d_rdy", 32'(o_d_ca_rdy), 1);
      tick();
      settle();
      check("wmax_d_rdy", 32'(o_d_ca_rdy), 0);
      check("wmax_m_vld", 32'(o_m_ca_vld), 0);
      i_d_ca_vld = 1'b0;
      // one response (head = I) frees a slot for the waiting I read
      i_m_rd_vld = 1'b1; i_m_rd_dat = 32'hA1;
      settle();
      check("resp0_i_vld",  32'(o_i_rd_vld), 1);
      check("resp0_d_vld",  32'(o_d_rd_vld), 0);
      check("resp0_i_dat",  o_i_rd_dat, 32'hA1);
      check("resp0_i_rdy",  32'(o_i_ca_rdy), 0);
      tick();
      i_m_rd_vld = 1'b0;
      settle();
      check("pop_i_ca_rdy", 32'(o_i_ca_rdy), 1);
      tick();
      i_i_ca_vld = 1'b0;
      // order now D, I, D, I
      for (int k = 0; k < 4; k++) begin
         logic exp_d;
         exp_d = !k[0];
         i_m_rd_vld = 1'b1; i_m_rd_dat = 32'hB0 + 32'(k);
         settle();
         check("drain_i_vld", 32'(o_i_rd_vld), 32'(!exp_d));
         check("drain_d_vld", 32'(o_d_rd_vld), 32'(exp_d));
         check("drain_dat", exp_d ? o_d_rd_dat : o_i_rd_dat, 32'hB0 + 32'(k));
         tick();
      end
      i_m_rd_vld = 1'b0;
      // two pending write beats
      i_d_dm_vld = 1'b1; i_d_dm_dat = 32'hDEAD0001; i_d_dm_msk = 4'h5;
      settle();
      check("dmq_vld", 32'(o_m_dm_vld), 1);
      check("dmq_dat", o_m_dm_dat, 32'hDEAD0001);
      check("dmq_msk", 32'(o_m_dm_msk), 32'h5);
      tick(); tick();
      settle();
      check("dmq_done_vld", 32'(o_m_dm_vld), 0);
      check("dmq_done_rdy", 32'(o_d_dm_rdy), 0);

      // ---- dm forwarded only one cycle after its command ----
      i_d_ca_vld = 1'b1; i_d_ca_cmd = 1'b1; i_d_ca_adr = 32'h300;
      i_d_dm_dat = 32'h12345678; i_d_dm_msk = 4'hF;
      settle();
      check("dm0_vld",    32'(o_m_dm_vld), 0);
      check("dm0_ca_rdy", 32'(o_d_ca_rdy), 1);
      tick();
      i_d_ca_vld = 1'b0;
      settle();
      check("dm1_vld", 32'(o_m_dm_vld), 1);
      check("dm1_rdy", 32'(o_d_dm_rdy), 1);
      check("dm1_dat", o_m_dm_dat, 32'h12345678);
      tick();
      settle();
      check("dm2_vld", 32'(o_m_dm_vld), 0);
      i_d_dm_vld = 1'b0;

      // ---- lock under backpressure (last grant was D, so I would win a tie) ----
      i_m_ca_rdy = 1'b0;
      i_d_ca_vld = 1'b1; i_d_ca_cmd = 1'b0; i_d_ca_adr = 32'h400;
      settle();
      check("lk1_adr",   o_m_ca_adr, 32'h400);
      check("lk1_d_rdy", 32'(o_d_ca_rdy), 0);
      tick();
      i_i_ca_vld = 1'b1; i_i_ca_adr = 32'h500;
      settle();
      check("lk2_adr",   o_m_ca_adr, 32'h400);
      check("lk2_i_rdy", 32'(o_i_ca_rdy), 0);
      tick();
      settle();
      check("lk3_adr", o_m_ca_adr, 32'h400);
      tick();
      i_m_ca_rdy = 1'b1;
      settle();
      check("lk4_d_rdy", 32'(o_d_ca_rdy), 1);
      check("lk4_i_rdy", 32'(o_i_ca_rdy), 0);
      check("lk4_adr",   o_m_ca_adr, 32'h400);
      tick();
      i_d_ca_vld = 1'b0;
      settle();
      check("lk5_i_rdy", 32'(o_i_ca_rdy), 1);
      check("lk5_adr",   o_m_ca_adr, 32'h500);
      tick();
      i_i_ca_vld = 1'b0;
      i_m_rd_vld = 1'b1; i_m_rd_dat = 32'hC0;
      settle();
      check("lkr0_d_vld", 32'(o_d_rd_vld), 1);
      tick();
      i_m_rd_dat = 32'hC1;
      settle();
      check("lkr1_i_vld", 32'(o_i_rd_vld), 1);
      tick();
      i_m_rd_vld = 1'b0;

      // ---- in-order return with I backpressure ----
      i_i_ca_vld = 1'b1; i_i_ca_adr = 32'h600;
      settle();
      check("bp_iss_i", 32'(o_i_ca_rdy), 1);
      tick();
      i_i_ca_vld = 1'b0;
      i_d_ca_vld = 1'b1; i_d_ca_cmd = 1'b0; i_d_ca_adr = 32'h700;
      settle();
      check("bp_iss_d", 32'(o_d_ca_rdy), 1);
      tick();
      i_d_ca_vld = 1'b0;
      i_m_rd_vld = 1'b1; i_m_rd_dat = 32'hAAAA; i_i_rd_rdy = 1'b0;
      for (int k = 0; k < 2; k++) begin
         settle();
         check("bp_m_rdy", 32'(o_m_rd_rdy), 0);
         check("bp_i_vld", 32'(o_i_rd_vld), 1);
         check("bp_d_vld", 32'(o_d_rd_vld), 0);
         tick();
      end
      i_i_rd_rdy = 1'b1;
      settle();
      check("bpA_m_rdy", 32'(o_m_rd_rdy), 1);
      check("bpA_dat",   o_i_rd_dat, 32'hAAAA);
      tick();
      i_m_rd_dat = 32'hBBBB;
      settle();
      check("bpB_d_vld", 32'(o_d_rd_vld), 1);
      check("bpB_i_vld", 32'(o_i_rd_vld), 0);
      check("bpB_dat",   o_d_rd_dat, 32'hBBBB);
      tick();
      i_m_rd_vld = 1'b0;

      // ---- stray read data sets sticky error ----
      i_i_rd_rdy = 1'b0; i_d_rd_rdy = 1'b0;
      i_m_rd_vld = 1'b1; i_m_rd_dat = 32'hEEEE;
      settle();
      check("err0",        32'(o_err), 0);
      check("stray_m_rdy", 32'(o_m_rd_rdy), 1);
      check("stray_i_vld", 32'(o_i_rd_vld), 0);
      check("stray_d_vld", 32'(o_d_rd_vld), 0);
      tick();
      i_m_rd_vld = 1'b0;
      settle();
      check("err1", 32'(o_err), 1);
      tick();
      check("err_sticky", 32'(o_err), 1);

      // ---- reset mid-burst clears FIFO, wcnt and error ----
      i_i_rd_rdy = 1'b1; i_d_rd_rdy = 1'b1;
      i_i_ca_vld = 1'b1; i_i_ca_adr = 32'h800;
      tick();
      i_i_ca_vld = 1'b0;
      i_d_ca_vld = 1'b1; i_d_ca_cmd = 1'b1; i_d_ca_adr = 32'h900;
      tick();
      i_d_ca_vld = 1'b0;
      resetn = 1'b0;
      settle();
      check("rst2_err",      32'(o_err), 0);
      check("rst2_m_rd_rdy", 32'(o_m_rd_rdy), 0);
      tick();
      resetn = 1'b1;
      i_m_rd_vld = 1'b1; i_m_rd_dat = 32'h1234;
      i_d_dm_vld = 1'b1;
      settle();
      check("post_i_vld",  32'(o_i_rd_vld), 0);
      check("post_m_rdy",  32'(o_m_rd_rdy), 1);
      check("post_dm_vld", 32'(o_m_dm_vld), 0);
      tick();
      i_m_rd_vld = 1'b0; i_d_dm_vld = 1'b0;
      settle();
      check("post_err", 32'(o_err), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
